// File: rtl/vball_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vball_pkg: shared types and constants for the graphics ROM path. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package vball_pkg;

  localparam int         GFX_AW           = 19;
  localparam logic [7:0] GFX_TIMEOUT_DATA = 8'hFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_BG = 2'd1,
    BUSY_SP = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/vball_gfx_arb_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vball_gfx_arb_if: requester and external gfx ROM signals.        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface vball_gfx_arb_if
  import vball_pkg::*;
#(
  parameter int AW = GFX_AW
) ();

  logic          hb;
  logic          bg_req;
  logic [AW-1:0] bg_addr;
  logic          bg_ack;
  logic [7:0]    bg_data;
  logic          sp_req;
  logic [AW-1:0] sp_addr;
  logic          sp_ack;
  logic [7:0]    sp_data;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data;
  logic          mem_rdy;
  logic          err;

  // The arbiter itself.
  modport master (
    input  hb, bg_req, bg_addr, sp_req, sp_addr, mem_data, mem_rdy,
    output bg_ack, bg_data, sp_ack, sp_data, mem_rd, mem_addr, err
  );

  // Requesters and memory seen from the outside.
  modport slave (
    output hb, bg_req, bg_addr, sp_req, sp_addr, mem_data, mem_rdy,
    input  bg_ack, bg_data, sp_ack, sp_data, mem_rd, mem_addr, err
  );

endinterface
`default_nettype wire

// File: rtl/vball_gfx_wdog.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vball_gfx_wdog: per-transaction cycle counter for a stalled ROM. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module vball_gfx_wdog
  import vball_pkg::*;
#(
  parameter logic [7:0] TIMEOUT = 8'd64
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] r_cnt;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_cnt <= 8'd0;
    end else if (clear) begin
      r_cnt <= 8'd0;
    end else if (enable) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign expired = (r_cnt == TIMEOUT - 8'd1);

endmodule
`default_nettype wire

// File: rtl/vball_gfx_arb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vball_gfx_arb: shares the external gfx ROM port between bg/sprite.|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module vball_gfx_arb
  import vball_pkg::*;
#(
  parameter int         AW      = GFX_AW,
  parameter logic [3:0] STARVE  = 4'd8,
  parameter logic [7:0] TIMEOUT = 8'd64
) (
  input  logic             clk_sys,
  input  logic             reset,
  vball_gfx_arb_if.master  bus
);

  arb_state_t    r_state, w_state_nxt;
  logic          r_mem_rd, w_mem_rd_nxt;
  logic [AW-1:0] r_mem_addr, w_mem_addr_nxt;
  logic          r_bg_ack, w_bg_ack_nxt;
  logic          r_sp_ack, w_sp_ack_nxt;
  logic [7:0]    r_bg_data, w_bg_data_nxt;
  logic [7:0]    r_sp_data, w_sp_data_nxt;
  logic          r_err, w_err_nxt;
  logic [3:0]    r_sp_wait, w_sp_wait_nxt;
  logic          w_wd_clear, w_wd_en, w_wd_expired;
  logic          w_done;
  logic [7:0]    w_done_data;

  vball_gfx_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk_sys (clk_sys),
    .reset   (reset),
    .clear   (w_wd_clear),
    .enable  (w_wd_en),
    .expired (w_wd_expired)
  );

  // A real completion always beats a coincident timeout.
  assign w_done      = bus.mem_rdy || w_wd_expired;
  assign w_done_data = bus.mem_rdy ? bus.mem_data : GFX_TIMEOUT_DATA;

  always_comb begin
    w_state_nxt    = r_state;
    w_mem_rd_nxt   = r_mem_rd;
    w_mem_addr_nxt = r_mem_addr;
    w_bg_ack_nxt   = 1'b0;
    w_sp_ack_nxt   = 1'b0;
    w_bg_data_nxt  = r_bg_data;
    w_sp_data_nxt  = r_sp_data;
    w_err_nxt      = r_err;
    w_wd_clear     = 1'b0;
    w_wd_en        = 1'b0;
    w_sp_wait_nxt  = r_sp_wait;

    if (!bus.sp_req) begin
      w_sp_wait_nxt = 4'd0;
    end else if (r_state != BUSY_SP && r_sp_wait != 4'hF) begin
      w_sp_wait_nxt = r_sp_wait + 4'd1;
    end

    case (r_state)
      IDLE: begin
        if (bus.sp_req && (!bus.bg_req || bus.hb || r_sp_wait >= STARVE)) begin
          w_state_nxt    = BUSY_SP;
          w_mem_rd_nxt   = 1'b1;
          w_mem_addr_nxt = bus.sp_addr;
          w_wd_clear     = 1'b1;
          w_sp_wait_nxt  = 4'd0;
        end else if (bus.bg_req) begin
          w_state_nxt    = BUSY_BG;
          w_mem_rd_nxt   = 1'b1;
          w_mem_addr_nxt = bus.bg_addr;
          w_wd_clear     = 1'b1;
        end
      end
      BUSY_BG, BUSY_SP: begin
        w_wd_en = 1'b1;
        if (w_done) begin
          w_state_nxt  = IDLE;
          w_mem_rd_nxt = 1'b0;
          if (!bus.mem_rdy) w_err_nxt = 1'b1;
          if (r_state == BUSY_BG) begin
            w_bg_ack_nxt  = 1'b1;
            w_bg_data_nxt = w_done_data;
          end else begin
            w_sp_ack_nxt  = 1'b1;
            w_sp_data_nxt = w_done_data;
          end
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_mem_rd_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state    <= IDLE;
      r_mem_rd   <= 1'b0;
      r_mem_addr <= '0;
      r_bg_ack   <= 1'b0;
      r_sp_ack   <= 1'b0;
      r_bg_data  <= 8'd0;
      r_sp_data  <= 8'd0;
      r_err      <= 1'b0;
      r_sp_wait  <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_mem_rd   <= w_mem_rd_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_bg_ack   <= w_bg_ack_nxt;
      r_sp_ack   <= w_sp_ack_nxt;
      r_bg_data  <= w_bg_data_nxt;
      r_sp_data  <= w_sp_data_nxt;
      r_err      <= w_err_nxt;
      r_sp_wait  <= w_sp_wait_nxt;
    end
  end

  assign bus.mem_rd   = r_mem_rd;
  assign bus.mem_addr = r_mem_addr;
  assign bus.bg_ack   = r_bg_ack;
  assign bus.sp_ack   = r_sp_ack;
  assign bus.bg_data  = r_bg_data;
  assign bus.sp_data  = r_sp_data;
  assign bus.err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_vball_gfx_arb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_vball_gfx_arb: directed vectors plus random traffic vs model. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_vball_gfx_arb;
  import vball_pkg::*;

  localparam int         AW      = GFX_AW;
  localparam logic [3:0] STARVE  = 4'd8;
  localparam logic [7:0] TIMEOUT = 8'd64;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  vball_gfx_arb_if #(.AW(AW)) bus ();

  vball_gfx_arb #(.AW(AW), .STARVE(STARVE), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction-level reference: who owns the port, how long it has been out,
  // and how long the sprite has been refused.
  int            m_owner;   // 0 none, 1 background, 2 sprite
  int            m_age;
  int            m_wait;
  int            m_next_wait;
  logic          m_rd;
  logic [AW-1:0] m_addr;
  logic          m_bg_ack, m_sp_ack, m_err;
  logic [7:0]    m_bg_data, m_sp_data, m_d;
  bit            m_valid = 1'b0;

  always @(posedge clk_sys) begin
    if (reset) begin
      m_owner = 0; m_age = 0; m_wait = 0; m_rd = 1'b0; m_addr = '0;
      m_bg_ack = 1'b0; m_sp_ack = 1'b0; m_bg_data = 8'd0; m_sp_data = 8'd0;
      m_err = 1'b0; m_valid = 1'b1;
    end else if (m_valid) begin
      m_bg_ack = 1'b0;
      m_sp_ack = 1'b0;
      if (!bus.sp_req)       m_next_wait = 0;
      else if (m_owner == 2) m_next_wait = m_wait;
      else                   m_next_wait = (m_wait < 15) ? m_wait + 1 : 15;
      if (m_owner == 0) begin
        if (bus.sp_req && (!bus.bg_req || bus.hb || m_wait >= int'(STARVE))) begin
          m_owner = 2; m_addr = bus.sp_addr; m_rd = 1'b1; m_age = 0; m_next_wait = 0;
        end else if (bus.bg_req) begin
          m_owner = 1; m_addr = bus.bg_addr; m_rd = 1'b1; m_age = 0;
        end
      end else if (bus.mem_rdy || m_age == int'(TIMEOUT) - 1) begin
        m_d = bus.mem_rdy ? bus.mem_data : 8'hFF;
        if (!bus.mem_rdy) m_err = 1'b1;
        if (m_owner == 1) begin m_bg_ack = 1'b1; m_bg_data = m_d; end
        else              begin m_sp_ack = 1'b1; m_sp_data = m_d; end
        m_owner = 0;
        m_rd    = 1'b0;
      end else begin
        m_age++;
      end
      m_wait = m_next_wait;
    end
  end

  always @(negedge clk_sys) begin
    if (m_valid)
      check("model", {bus.mem_rd, bus.mem_addr, bus.bg_ack, bus.bg_data, bus.sp_ack, bus.sp_data, bus.err},
                     {m_rd, m_addr, m_bg_ack, m_bg_data, m_sp_ack, m_sp_data, m_err});
  end

  typedef struct {
    logic hb;
    logic bg;
    logic sp;
    int   exp;   // 0 no grant, 1 background, 2 sprite
  } vec_t;

  vec_t          vecs[8];
  int            ack_cnt, sp_seen, grant_at, rd_cycles;
  bit            found, got, stall, prev_rd;
  logic [AW-1:0] sp_a;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 2};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 2};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 2};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 0};

    bus.hb = 1'b0; bus.bg_req = 1'b0; bus.bg_addr = '0; bus.sp_req = 1'b0;
    bus.sp_addr = '0; bus.mem_data = 8'd0; bus.mem_rdy = 1'b0;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    check("reset_outputs", {bus.mem_rd, bus.mem_addr, bus.bg_ack, bus.bg_data, bus.sp_ack, bus.sp_data, bus.err}, 64'd0);
    reset = 1'b0;

    // Grant decision table, sprite wait counter at zero for each vector.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_sys);
      bus.hb = vecs[i].hb; bus.bg_req = vecs[i].bg; bus.sp_req = vecs[i].sp;
      bus.bg_addr = 19'h01000 + AW'(i); bus.sp_addr = 19'h42000 + AW'(i);
      @(negedge clk_sys);
      check($sformatf("vec%0d_rd", i), bus.mem_rd, (vecs[i].exp != 0));
      if (vecs[i].exp != 0)
        check($sformatf("vec%0d_addr", i), bus.mem_addr, (vecs[i].exp == 1) ? bus.bg_addr : bus.sp_addr);
      bus.bg_req = 1'b0; bus.sp_req = 1'b0; bus.hb = 1'b0;
      bus.mem_rdy = (vecs[i].exp != 0); bus.mem_data = 8'h30 + 8'(i);
      @(negedge clk_sys);
      check($sformatf("vec%0d_acks", i), {bus.bg_ack, bus.sp_ack}, {vecs[i].exp == 1, vecs[i].exp == 2});
      if (vecs[i].exp != 0)
        check($sformatf("vec%0d_data", i), (vecs[i].exp == 1) ? bus.bg_data : bus.sp_data, 8'h30 + 8'(i));
      bus.mem_rdy = 1'b0;
      @(negedge clk_sys);
    end

    // Single background read, memory answers three cycles after mem_rd.
    bus.bg_req = 1'b1; bus.bg_addr = 19'h01234;
    @(negedge clk_sys);
    check("single_rd", bus.mem_rd, 1'b1);
    check("single_addr", bus.mem_addr, 19'h01234);
    ack_cnt = 0; sp_seen = 0;
    for (int c = 0; c < 8; c++) begin
      bus.mem_rdy = (c == 2); bus.mem_data = 8'hA5;
      @(negedge clk_sys);
      if (bus.bg_ack) begin ack_cnt++; bus.bg_req = 1'b0; end
      if (bus.sp_ack) sp_seen++;
    end
    bus.mem_rdy = 1'b0;
    check("single_ack_once", ack_cnt, 1);
    check("single_data", bus.bg_data, 8'hA5);
    check("single_no_sp_ack", sp_seen, 0);

    // Continuous background traffic with a one-cycle memory; sprite held.
    bus.bg_req = 1'b1; bus.sp_req = 1'b1; bus.hb = 1'b0;
    bus.bg_addr = 19'h10000; sp_a = 19'h7ABCD; bus.sp_addr = sp_a;
    found = 1'b0; grant_at = -1;
    for (int c = 1; c <= 30 && !found; c++) begin
      @(negedge clk_sys);
      if (bus.mem_rd && bus.mem_addr == sp_a) begin found = 1'b1; grant_at = c; end
      bus.mem_rdy = bus.mem_rd; bus.mem_data = 8'(c);
      if (bus.bg_ack) bus.bg_addr = bus.bg_addr + 19'd1;
    end
    check("starve_grant_edge", grant_at, 9);
    @(negedge clk_sys);
    check("starve_sp_ack", bus.sp_ack, found);
    bus.bg_req = 1'b0; bus.sp_req = 1'b0; bus.mem_rdy = 1'b0;
    @(negedge clk_sys);

    // Memory never answers.
    bus.bg_req = 1'b1; bus.bg_addr = 19'h05555;
    rd_cycles = 0; got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk_sys);
      if (bus.mem_rd) rd_cycles++;
      if (bus.bg_ack) begin got = 1'b1; bus.bg_req = 1'b0; end
    end
    check("tmo_ack", got, 1'b1);
    check("tmo_rd_cycles", rd_cycles, 64);
    check("tmo_data", bus.bg_data, 8'hFF);
    check("tmo_err", bus.err, 1'b1);
    @(negedge clk_sys);
    bus.bg_req = 1'b1; bus.bg_addr = 19'h05556;
    @(negedge clk_sys);
    bus.mem_rdy = 1'b1; bus.mem_data = 8'h5A;
    @(negedge clk_sys);
    check("after_tmo_ack", bus.bg_ack, 1'b1);
    check("after_tmo_data", bus.bg_data, 8'h5A);
    check("err_sticky", bus.err, 1'b1);
    bus.bg_req = 1'b0; bus.mem_rdy = 1'b0;
    @(negedge clk_sys);

    // Reset while the sprite transaction is in flight, then a late mem_rdy.
    bus.sp_req = 1'b1; bus.sp_addr = 19'h3C3C3;
    @(negedge clk_sys);
    check("rst_sp_granted", {bus.mem_rd, bus.mem_addr}, {1'b1, 19'h3C3C3});
    @(negedge clk_sys);
    reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0; bus.sp_req = 1'b0; bus.mem_rdy = 1'b1; bus.mem_data = 8'h77;
    @(negedge clk_sys);
    bus.mem_rdy = 1'b0;
    check("rst_outputs", {bus.mem_rd, bus.mem_addr, bus.bg_ack, bus.bg_data, bus.sp_ack, bus.sp_data, bus.err}, 64'd0);
    bus.bg_req = 1'b1; bus.bg_addr = 19'h0ABCD;
    @(negedge clk_sys);
    check("rst_next_grant", {bus.mem_rd, bus.mem_addr}, {1'b1, 19'h0ABCD});
    bus.mem_rdy = 1'b1; bus.mem_data = 8'h11;
    @(negedge clk_sys);
    check("rst_next_ack", {bus.bg_ack, bus.bg_data}, {1'b1, 8'h11});
    bus.bg_req = 1'b0; bus.mem_rdy = 1'b0;
    @(negedge clk_sys);

    // Random traffic; every cycle is compared against the model.
    stall = 1'b0; prev_rd = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_sys);
      reset = ($urandom_range(0, 499) == 0);
      if (bus.mem_rd) begin
        if (!prev_rd) stall = ($urandom_range(0, 39) == 0);
        bus.mem_rdy = !stall && ($urandom_range(0, 2) == 0);
      end else begin
        bus.mem_rdy = ($urandom_range(0, 29) == 0);
      end
      prev_rd = bus.mem_rd;
      bus.mem_data = 8'($urandom);
      if (bus.bg_ack) begin
        if ($urandom_range(0, 1) == 1) bus.bg_addr = AW'($urandom);
        else bus.bg_req = 1'b0;
      end else if (!bus.bg_req && $urandom_range(0, 2) == 0) begin
        bus.bg_req = 1'b1; bus.bg_addr = AW'($urandom);
      end
      if (bus.sp_ack) begin
        if ($urandom_range(0, 1) == 1) bus.sp_addr = AW'($urandom);
        else bus.sp_req = 1'b0;
      end else if (!bus.sp_req && $urandom_range(0, 2) == 0) begin
        bus.sp_req = 1'b1; bus.sp_addr = AW'($urandom);
      end
      if ($urandom_range(0, 9) == 0) bus.hb = ~bus.hb;
    end
    reset = 1'b0; bus.bg_req = 1'b0; bus.sp_req = 1'b0; bus.mem_rdy = 1'b0; bus.hb = 1'b0;
    repeat (3) @(negedge clk_sys);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
